// File: rtl/ctrl_issue_seq.sv
// ctrl_issue_seq: issue sequencer between the control decoder and execute.
// Holds one decoded instruction in a registered issue slot, stretches mul/div
// over MUL_CYC/DIV_CYC cycles, squashes illegal encodings, drops the slot on a
// branch/jump flush and parks the core after a halt (opcode 15) issues.
// Optional feature macro: CTRL_ISSUE_PERF_EN adds saturating perf counters
// perf_issued (legal accepts) and perf_stall (offered but not accepted, not
// halted). With the macro undefined neither the ports nor the counters exist.

module ctrl_issue_seq #(
  parameter int CTRL_W  = 14,
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_funct,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_last,
  output logic [3:0]        ex_opcode,
  output logic [3:0]        ex_funct,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              illegal,
  output logic              halted
`ifdef CTRL_ISSUE_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  // Remaining-cycle counter reload values; a 1-cycle op reloads 0.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYC - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYC - 1);

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_HALT = 4'd15;
  localparam logic [3:0] FN_MUL  = 4'b0100;
  localparam logic [3:0] FN_DIV  = 4'b1000;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MULTI  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ex_valid_q, ex_valid_d;
  logic [3:0]          ex_opcode_q, ex_opcode_d;
  logic [3:0]          ex_funct_q, ex_funct_d;
  logic [CTRL_W-1:0]   ex_ctrl_q, ex_ctrl_d;
  logic                illegal_q, illegal_d;
  logic                halted_q, halted_d;

  logic                in_ready_s;
  logic                accept_s;
  logic                legal_s;
  logic                halt_issuing_s;
  logic                issue_s;

  // Legal encoding table: opcode 0 is further qualified by functcode.
  function automatic logic is_legal(input logic [3:0] op, input logic [3:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      4'd0: begin
        case (fn)
          4'b0000, 4'b0001, 4'b0100,
          4'b1000, 4'b1110, 4'b1111: ok = 1'b1;
          default:                   ok = 1'b0;
        endcase
      end
      4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8,
      4'd9, 4'd10, 4'd11, 4'd12, 4'd15: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Cycles left after the first execute cycle for the offered instruction.
  function automatic logic [3:0] cnt_load(input logic [3:0] op, input logic [3:0] fn);
    logic [3:0] ld;
    ld = 4'd0;
    if (op == OP_ALU && fn == FN_MUL) begin
      ld = MUL_LOAD;
    end else if (op == OP_ALU && fn == FN_DIV) begin
      ld = DIV_LOAD;
    end else begin
      ld = 4'd0;
    end
    return ld;
  endfunction

  // Handshake and slot-status decode shared by next-state and counters.
  always_comb begin
    in_ready_s     = !rst && !flush && (state_q != ST_HALTED) && (cnt_q == 4'd0);
    accept_s       = in_valid && in_ready_s;
    legal_s        = is_legal(in_opcode, in_funct);
    // A halt in its single issue cycle parks the core on the next edge; that
    // transition wins over anything offered in the same cycle.
    halt_issuing_s = ex_valid_q && (cnt_q == 4'd0) && (ex_opcode_q == OP_HALT)
                     && (state_q != ST_HALTED);
    issue_s        = accept_s && legal_s && !halt_issuing_s;
  end

  // Issue-slot next state: halted > flush > halt parking > accept > countdown > drain.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    ex_funct_d  = ex_funct_q;
    ex_ctrl_d   = ex_ctrl_q;
    illegal_d   = 1'b0;
    halted_d    = halted_q;

    if (state_q == ST_HALTED) begin
      // Parked until reset; flush and inputs are ignored.
      ex_valid_d = 1'b0;
      cnt_d      = 4'd0;
      halted_d   = 1'b1;
    end else if (flush) begin
      ex_valid_d = 1'b0;
      cnt_d      = 4'd0;
      state_d    = ST_EMPTY;
    end else if (halt_issuing_s) begin
      ex_valid_d = 1'b0;
      cnt_d      = 4'd0;
      halted_d   = 1'b1;
      state_d    = ST_HALTED;
    end else if (accept_s) begin
      if (legal_s) begin
        ex_valid_d  = 1'b1;
        ex_opcode_d = in_opcode;
        ex_funct_d  = in_funct;
        ex_ctrl_d   = in_ctrl;
        cnt_d       = cnt_load(in_opcode, in_funct);
        if (cnt_load(in_opcode, in_funct) != 4'd0) begin
          state_d = ST_MULTI;
        end else begin
          state_d = ST_EXEC;
        end
      end else begin
        // Squash: the slot becomes a bubble and the pulse reports it.
        ex_valid_d  = 1'b0;
        ex_opcode_d = 4'd0;
        ex_funct_d  = 4'd0;
        ex_ctrl_d   = {CTRL_W{1'b0}};
        cnt_d       = 4'd0;
        illegal_d   = 1'b1;
        state_d     = ST_EMPTY;
      end
    end else if (cnt_q != 4'd0) begin
      // Multi-cycle op keeps its slot contents; only the counter moves.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = ST_EXEC;
      end else begin
        state_d = ST_MULTI;
      end
    end else begin
      ex_valid_d = 1'b0;
      state_d    = ST_EMPTY;
    end
  end

  // Issue-slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= 4'd0;
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= 4'd0;
      ex_funct_q  <= 4'd0;
      ex_ctrl_q   <= {CTRL_W{1'b0}};
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      ex_funct_q  <= ex_funct_d;
      ex_ctrl_q   <= ex_ctrl_d;
      illegal_q   <= illegal_d;
      halted_q    <= halted_d;
    end
  end

`ifdef CTRL_ISSUE_PERF_EN
  logic [15:0] perf_issued_q, perf_issued_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // Saturating event counters for issued instructions and stalled offers.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (issue_s && (perf_issued_q != 16'hFFFF)) begin
      perf_issued_d = perf_issued_q + 16'd1;
    end else begin
      perf_issued_d = perf_issued_q;
    end
    if (in_valid && !in_ready_s && !halted_q && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Perf counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= 16'd0;
      perf_stall_q  <= 16'd0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`else
  logic unused_issue_s;
  assign unused_issue_s = issue_s;
`endif

  assign in_ready  = in_ready_s;
  assign ex_last   = ex_valid_q && (cnt_q == 4'd0);
  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_funct  = ex_funct_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_issue_seq.sv
// tb_ctrl_issue_seq: directed-vector bench for ctrl_issue_seq (default params).
// Inputs change 1 time unit after each rising edge; outputs are observed at
// the same point, i.e. the values produced by that edge.

module tb_ctrl_issue_seq;

  localparam int CTRL_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [3:0]        in_funct;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              ex_valid;
  logic              ex_last;
  logic [3:0]        ex_opcode;
  logic [3:0]        ex_funct;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              illegal;
  logic              halted;
`ifdef CTRL_ISSUE_PERF_EN
  logic [15:0]       perf_issued;
  logic [15:0]       perf_stall;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  ctrl_issue_seq #(.CTRL_W(CTRL_W), .MUL_CYC(4), .DIV_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_funct  (in_funct),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_last   (ex_last),
    .ex_opcode (ex_opcode),
    .ex_funct  (ex_funct),
    .ex_ctrl   (ex_ctrl),
    .illegal   (illegal),
    .halted    (halted)
`ifdef CTRL_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [3:0] fn, input logic [CTRL_W-1:0] c);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct  = fn;
    in_ctrl   = c;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    in_funct  = 4'd0;
    in_ctrl   = 14'd0;
    flush     = 1'b0;
    tick();
    tick();

    // Reset values, and in_ready gated by rst itself.
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_last",  32'(ex_last),  32'd0);
    chk("rst_ex_op",    32'(ex_opcode), 32'd0);
    chk("rst_ex_ctrl",  32'(ex_ctrl),  32'd0);
    chk("rst_illegal",  32'(illegal),  32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // add then sub back to back.
    offer(4'd0, 4'b0000, 14'h1A5);
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_ctrl",  32'(ex_ctrl),  32'h1A5);
    chk("add_last",  32'(ex_last),  32'd1);
    offer(4'd0, 4'b0001, 14'h2B6);
    tick();
    chk("sub_valid", 32'(ex_valid), 32'd1);
    chk("sub_ctrl",  32'(ex_ctrl),  32'h2B6);
    chk("sub_funct", 32'(ex_funct), 32'd1);
    chk("sub_last",  32'(ex_last),  32'd1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(ex_valid), 32'd0);
    chk("drain_last",  32'(ex_last),  32'd0);

    // div then add offered continuously: 16 cycles, 15 not-ready.
    do_reset();
    offer(4'd0, 4'b1000, 14'h3C7);
    tick();
    offer(4'd0, 4'b0000, 14'h0D8);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("div_valid_%0d", k), 32'(ex_valid), 32'd1);
      chk($sformatf("div_ctrl_%0d", k),  32'(ex_ctrl),  32'h3C7);
      chk($sformatf("div_last_%0d", k),  32'(ex_last),  (k == 16) ? 32'd1 : 32'd0);
      chk($sformatf("div_rdy_%0d", k),   32'(in_ready), (k == 16) ? 32'd1 : 32'd0);
      tick();
    end
    chk("post_div_add_valid", 32'(ex_valid), 32'd1);
    chk("post_div_add_ctrl",  32'(ex_ctrl),  32'h0D8);
    chk("post_div_add_last",  32'(ex_last),  32'd1);
`ifdef CTRL_ISSUE_PERF_EN
    chk("perf_issued", 32'(perf_issued), 32'd2);
    chk("perf_stall",  32'(perf_stall),  32'd15);
`endif
    in_valid = 1'b0;
    tick();
    chk("post_div_empty", 32'(ex_valid), 32'd0);

    // Full mul: exactly 4 execute cycles, ex_last on the 4th.
    offer(4'd0, 4'b0100, 14'h0F1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul_valid_%0d", k), 32'(ex_valid), 32'd1);
      chk($sformatf("mul_last_%0d", k),  32'(ex_last),  (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("mul_done", 32'(ex_valid), 32'd0);

    // mul flushed on its 2nd execute cycle.
    offer(4'd0, 4'b0100, 14'h155);
    tick();
    in_valid = 1'b0;
    chk("mflush_c1_valid", 32'(ex_valid), 32'd1);
    tick();
    chk("mflush_c2_valid", 32'(ex_valid), 32'd1);
    offer(4'd1, 4'd0, 14'h0AA);
    flush = 1'b1;
    #1;
    chk("mflush_rdy_in_flush", 32'(in_ready), 32'd0);
    chk("mflush_last_c2",      32'(ex_last),  32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mflush_valid_after", 32'(ex_valid), 32'd0);
    chk("mflush_last_after",  32'(ex_last),  32'd0);
    chk("mflush_rdy_after",   32'(in_ready), 32'd1);
    tick();
    chk("mflush_still_empty", 32'(ex_valid), 32'd0);

    // Illegal funct squashed, then legal op issues; illegal opcode 3 too.
    offer(4'd0, 4'b0011, 14'h3FF);
    tick();
    chk("ill_pulse",  32'(illegal),  32'd1);
    chk("ill_valid",  32'(ex_valid), 32'd0);
    chk("ill_ctrl",   32'(ex_ctrl),  32'd0);
    offer(4'd1, 4'd5, 14'h123);
    tick();
    chk("ill_pulse_end", 32'(illegal),  32'd0);
    chk("legal_valid",   32'(ex_valid), 32'd1);
    chk("legal_ctrl",    32'(ex_ctrl),  32'h123);
    chk("legal_op",      32'(ex_opcode), 32'd1);
    offer(4'd3, 4'd0, 14'h222);
    tick();
    chk("ill_op3_pulse", 32'(illegal),  32'd1);
    chk("ill_op3_valid", 32'(ex_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("ill_op3_end", 32'(illegal), 32'd0);

    // Halt: one issue cycle, then parked; flush ignored; reset clears.
    offer(4'd15, 4'd0, 14'h0C3);
    tick();
    in_valid = 1'b0;
    chk("halt_issue_valid",  32'(ex_valid),  32'd1);
    chk("halt_issue_last",   32'(ex_last),   32'd1);
    chk("halt_issue_op",     32'(ex_opcode), 32'd15);
    chk("halt_issue_halted", 32'(halted),    32'd0);
    tick();
    offer(4'd0, 4'd0, 14'h011);
    for (int k = 0; k < 20; k++) begin
      flush = (k == 5) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("halted_%0d", k),  32'(halted),   32'd1);
      chk($sformatf("h_rdy_%0d", k),   32'(in_ready), 32'd0);
      chk($sformatf("h_valid_%0d", k), 32'(ex_valid), 32'd0);
      tick();
    end
    flush = 1'b0;
    do_reset();
    chk("unhalt_halted", 32'(halted),   32'd0);
    chk("unhalt_rdy",    32'(in_ready), 32'd1);
    chk("unhalt_valid",  32'(ex_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ctrl_issue_seq.md
# ctrl_issue_seq

Issue sequencer between the opcode/functcode control decoder and the execute stage. It accepts one decoded instruction per cycle over a valid/ready handshake: opcode, functcode and the 14-bit control word. It holds each instruction in a registered issue slot and stretches mul/div across multiple cycles. It also squashes illegal encodings, drops in-flight work on a branch/jump flush, and parks the core on halt.

## Interface
- CTRL_W, 14: control word width.
- MUL_CYC, 4: execute cycles for mul (opcode 0, funct 4'b0100); legal range 1..16.
- DIV_CYC, 16: execute cycles for div (opcode 0, funct 4'b1000); legal range 1..16.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoder offers an instruction.
- in_ready  out  1  sequencer accepts this cycle.
- in_opcode  in  4  opcode.
- in_funct  in  4  functcode.
- in_ctrl  in  CTRL_W  decoded control word.
- flush  in  1  taken branch/jump from execute; kill issue slot.
- ex_valid  out  1  issue slot holds a live instruction.
- ex_last  out  1  final execute cycle of the current instruction.
- ex_opcode  out  4  registered opcode.
- ex_funct  out  4  registered functcode.
- ex_ctrl  out  CTRL_W  registered control word, stable for the whole instruction.
- illegal  out  1  one-cycle pulse: accepted encoding was illegal and was squashed.
- halted  out  1  sticky; halt issued.

## Operation
- States: EMPTY (no live instruction), EXEC (single-cycle, cnt=0), MULTI (cnt>0), HALTED.
- Accept condition: in_valid && in_ready.
- in_ready = !rst && !flush && state!=HALTED && cnt==0.
- Legal encodings:
  - opcode 1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 15;
  - opcode 0 with funct in {0000, 0001, 0100, 1000, 1110, 1111}.
- Illegal encoding accepted: slot loads a bubble (ex_valid=0, ex_ctrl=0), illegal=1 next cycle, state EMPTY.
- Legal accept:
  - ex_* registers load the input and ex_valid=1.
  - cnt loads MUL_CYC-1 for mul, DIV_CYC-1 for div, and 0 otherwise.
- MULTI: cnt decrements each cycle, and ex_ctrl/ex_opcode/ex_funct hold. At cnt==0 the state is EXEC-equivalent (ex_last=1, in_ready=1).
- No accept and cnt==0: ex_valid clears next cycle (EMPTY).
- ex_last = ex_valid && cnt==0.
- Halt (opcode 15) accepted: issues normally for one cycle (ex_valid=1, ex_last=1), then the state becomes HALTED. Then ex_valid=0, halted=1 and in_ready=0 until rst.
- Flush:
  - next cycle ex_valid=0, cnt=0 and state EMPTY;
  - in_ready=0 during the flush cycle, so no input is taken;
  - flush in HALTED has no effect.
- Flush has priority over the cnt decrement and over accept. rst has priority over everything.

## Timing
- Issue latency: 1 cycle, from the accepting edge to ex_valid/ex_ctrl visible.
- Throughput: 1 instruction/cycle for single-cycle ops. Back-to-back after a multi-cycle op is allowed on its ex_last cycle.
- mul occupies exactly MUL_CYC consecutive ex_valid cycles and div exactly DIV_CYC. With the default DIV_CYC=16 the cycle count is 16 and ex_last is high only on the 16th.
- All outputs are registered except in_ready and ex_last (combinational from state/cnt/flush).
- Reset values: ex_valid=0, ex_last=0, ex_opcode=0, ex_funct=0, ex_ctrl=0, illegal=0, halted=0, cnt=0, state EMPTY.
- Reset mid-MULTI aborts without an ex_last pulse.
- in_* values are ignored whenever in_ready=0. The decoder must hold them stable while in_valid && !in_ready.

## Configuration
- CTRL_ISSUE_PERF_EN defined: adds outputs perf_issued[15:0] and perf_stall[15:0].
  - perf_issued counts legal accepts.
  - perf_stall counts cycles with in_valid && !in_ready && !halted.
  - Both are saturating at 16'hFFFF and cleared by rst.
- CTRL_ISSUE_PERF_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset, then add (op 0, funct 0) then sub (op 0, funct 1) on consecutive cycles -> ex_valid 1 for two cycles, ex_ctrl tracks each input one cycle later, ex_last=1 both cycles.
- div then add offered continuously -> ex_valid 16 cycles with constant ex_ctrl, in_ready low 15 cycles, add issues the cycle after ex_last.
- mul accepted, flush on its 2nd execute cycle -> ex_valid=0 next cycle, no ex_last, in_ready=1 the cycle after flush.
- op 0 funct 4'b0011 accepted -> illegal pulse one cycle, ex_valid stays 0, next legal op issues normally.
- op 15 (halt) -> one issue cycle, then halted=1, in_ready=0 held 20 cycles despite in_valid=1; rst clears it.
- With CTRL_ISSUE_PERF_EN: div then add -> perf_issued=2, perf_stall=15.
